// File: rtl/im_loader.sv
// im_loader: assembles a big-endian byte stream into 32-bit words
// and writes them to the instruction RAM at consecutive addresses.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start, word_count load request and number of words (1..2^ADDR_W)
//   in_valid, in_data byte stream from host
//   in_ready          byte accepted this cycle (RECV only)
//   we, waddr, wdata  instruction RAM write port
//   busy, done, err   status: load active, completion pulse, bad count
module im_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [ADDR_W:0] word_count,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    output logic            we,
    output logic [31:0]     waddr,
    output logic [31:0]     wdata,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        state;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_idx;
    // Only the first three bytes need holding; the fourth goes
    // straight into wdata together with them.
    logic [23:0]       shreg;

    logic xfer;
    logic cnt_ok;
    logic last;

    assign in_ready = (state == S_RECV);
    assign we       = (state == S_WRITE);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    assign xfer   = in_valid && in_ready;
    assign cnt_ok = (word_count != '0) && (word_count <= MAX_CNT);
    assign last   = ({1'b0, word_idx} == count - 1'b1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            waddr    <= BASE_ADDR;
            wdata    <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cnt_ok) begin
                            count    <= word_count;
                            word_idx <= '0;
                            byte_idx <= '0;
                            state    <= S_RECV;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (xfer) begin
                        byte_idx <= byte_idx + 2'd1;
                        shreg    <= {shreg[15:0], in_data};
                        if (byte_idx == 2'd3) begin
                            // Output regs update only here so they hold
                            // between writes while the next word builds.
                            wdata <= {shreg, in_data};
                            waddr <= BASE_ADDR +
                                     {{(30-ADDR_W){1'b0}}, word_idx, 2'b00};
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (last) begin
                        state <= S_DONE;
                    end else begin
                        word_idx <= word_idx + 1'b1;
                        byte_idx <= '0;
                        state    <= S_RECV;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
